arbitro_regs: RTL and testbench
===============================

# arbitro_regs

Round-robin arbiter and load sequencer for the shared 25-bit `regs` holding register. Up to `N_REQ` requesters each present a 25-bit word with a request line. The block selects one winner, drives the word onto `regs.in`, and pulses `regs.leer` for one cycle. It then enforces a hold window so downstream logic can read `regs.out` before the next load. It sits directly in front of `regs` and is the only agent allowed to drive `leer`.

## Interface
- `N_REQ`, 4, number of requesters (2..4)
- `WIDTH`, 25, data width; matches `regs`
- `ID_W`, 2, width of `grant_id`; `N_REQ <= 2**ID_W`
- `HOLD`, 3, cycles spent in the hold state after each load (1..15)

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req`  in  N_REQ  request per requester; level, held until `ack`
- `dato`  in  N_REQ*WIDTH  requester i's word at `[i*WIDTH +: WIDTH]`
- `ack`  out  N_REQ  one-hot, one-cycle pulse to the granted requester
- `reg_in`  out  WIDTH  to `regs.in`
- `leer`  out  1  to `regs.leer`; one-cycle load strobe
- `grant_id`  out  ID_W  index of the last granted requester
- `valido`  out  1  one-cycle pulse: `regs.out` now holds the new word
- `ocupado`  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, CARGA, ESPERA. All outputs are registered.
- **IDLE:**
  - If `req != 0` at the clock edge, select the winner by round-robin.
  - Search starts at pointer `ptr` and proceeds `ptr, ptr+1, …` modulo `N_REQ`.
  - At that same edge: `reg_in <= dato[winner]`, `grant_id <= winner`, `ack[winner] <= 1`, `leer <= 1`, and the state goes to CARGA.
  - If `req == 0`, the state stays IDLE and all strobes are 0.
- **CARGA:** lasts exactly one cycle, with `leer=1` and `ack` asserted. On exit:
  - `leer` and `ack` go to 0.
  - `ptr <= (winner+1) mod N_REQ`.
  - `valido <= 1`.
  - The hold counter loads `HOLD-1`.
  - The state goes to ESPERA.
- **ESPERA:**
  - `valido` is high only in the first ESPERA cycle.
  - The counter decrements each cycle. When the counter is 0, the state goes to IDLE.
  - `reg_in` and `grant_id` hold their values.
- The data word is sampled only at the grant edge. `dato` may change afterwards without effect.
- Requests are not latched. A `req` that is raised and dropped entirely inside CARGA/ESPERA is lost: no `ack`, no load.
- A `req` still high after its `ack` counts as a new request at the next IDLE. Round-robin still applies, so other pending requesters win first.
- Simultaneous requests are resolved only by the `ptr` rotation. No requester has fixed priority.
- **Reset (`rst_n=0` at an edge):**
  - State IDLE, `ptr=0`, counter 0.
  - `reg_in=0`, `leer=0`, `ack=0`, `grant_id=0`, `valido=0`, `ocupado=0`.
  - Reset overrides every transition, including mid-CARGA (no `ack` or `leer` in the following cycle) and mid-ESPERA.
- Reset does not clear `regs` itself; that register has no reset.

## Timing
- Edge E0: IDLE samples `req`. Cycle E0→E1 is CARGA (`leer=1`, `ack=1`).
- `regs` captures at E1. Cycle E1→E2 has `valido=1` and `regs.out` equal to the new word.
- ESPERA occupies HOLD cycles, E1..E1+HOLD. The state returns to IDLE at E1+HOLD.
- Next earliest grant edge: E1+HOLD+1. Minimum `leer` spacing is therefore `HOLD+2` cycles (5 with default parameters).
- Latency from `req` rising (sampled in IDLE) to `leer`: 1 cycle. Latency to `valido`: 2 cycles.
- `ocupado` is high from E0 through E1+HOLD, i.e. HOLD+1 cycles per load.

## Test plan
- **Reset:** hold `rst_n=0` for 2 cycles with `req=4'hF`.
  - Required: all outputs 0 and `leer` never asserted.
  - After release, the first grant goes to requester 0.
- **Single request:** only `req[2]`, with `dato[2]=25'h1AAAAAA`.
  - Required: one `leer` pulse, `reg_in=25'h1AAAAAA`, `ack=4'b0100`, `grant_id=2`.
  - `valido` follows one cycle after `leer`, and `regs.out=25'h1AAAAAA` in the `valido` cycle.
- **Full contention:** `req=4'hF` held continuously, `HOLD=3`, distinct `dato` values.
  - Required: grant order 0,1,2,3,0, with `leer` pulses exactly 5 cycles apart.
  - `reg_in` matches each winner's word.
- **Rotation:** after a grant to requester 1, raise `req[1]` and `req[3]`.
  - Required: requester 3 is granted first, then requester 1.
- **Reset mid-operation:** drive `rst_n=0` for one cycle during CARGA with `req[1]` held.
  - Required: `leer`/`ack` are 0 in the next cycle and `ptr` returns to 0.
  - Requester 1 is re-granted after reset is released, with a fresh `ack`.
- **Lost pulse:** a 2-cycle `req[0]` pulse fully inside ESPERA.
  - Required: no `ack[0]`, no extra `leer`, and the state returns to IDLE with `ocupado=0`.

Source files
------------

// File: rtl/arbitro_regs_if.sv
// Requester-side bus of the regs load arbiter: request/data in, grant/load strobes out.
// master = requesters plus downstream regs, slave = arbiter.
interface arbitro_regs_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 25,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] dato;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       reg_in;
  logic                   leer;
  logic [ID_W-1:0]        grant_id;
  logic                   valido;
  logic                   ocupado;

  modport master (
    output req, dato,
    input  ack, reg_in, leer, grant_id, valido, ocupado
  );

  modport slave (
    input  req, dato,
    output ack, reg_in, leer, grant_id, valido, ocupado
  );
endinterface

// File: rtl/arbitro_regs.sv
// Round-robin arbiter that loads one requester's word into the shared regs
// holding register, then blocks further loads for HOLD cycles.
module arbitro_regs #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 25,
  parameter int ID_W  = 2,
  parameter int HOLD  = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  arbitro_regs_if.slave  io_bus
);
  localparam int IW = ID_W + 1;

  typedef enum logic [1:0] {IDLE, CARGA, ESPERA} state_t;

  state_t            r_state, w_state_next;
  logic [ID_W-1:0]   r_ptr, w_ptr_next, w_ptr_inc;
  logic [3:0]        r_cnt, w_cnt_next;
  logic [WIDTH-1:0]  r_reg_in, w_reg_in_next;
  logic [N_REQ-1:0]  r_ack, w_ack_next;
  logic              r_leer, w_leer_next;
  logic [ID_W-1:0]   r_grant_id, w_grant_id_next;
  logic              r_valido, w_valido_next;
  logic              r_ocupado;

  logic [IW-1:0]     w_idx [N_REQ];
  logic [WIDTH-1:0]  w_word [N_REQ];
  logic              w_found;
  logic [ID_W-1:0]   w_winner;

  // w_idx[k] is the requester visited k-th when the search starts at r_ptr
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      logic [IW-1:0] w_sum;
      assign w_sum      = {1'b0, r_ptr} + IW'(gi);
      assign w_idx[gi]  = (w_sum >= IW'(N_REQ)) ? w_sum - IW'(N_REQ) : w_sum;
      assign w_word[gi] = io_bus.dato[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Descending scan so the earliest position in the rotation wins
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (io_bus.req[w_idx[k][ID_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[k][ID_W-1:0];
      end
    end
  end

  assign w_ptr_inc = (r_grant_id == ID_W'(N_REQ - 1)) ? '0 : r_grant_id + 1'b1;

  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_cnt_next      = r_cnt;
    w_reg_in_next   = r_reg_in;
    w_grant_id_next = r_grant_id;
    w_ack_next      = '0;
    w_leer_next     = 1'b0;
    w_valido_next   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_next         = CARGA;
          w_reg_in_next        = w_word[w_winner];
          w_grant_id_next      = w_winner;
          w_ack_next[w_winner] = 1'b1;
          w_leer_next          = 1'b1;
        end
      end
      CARGA: begin
        w_state_next  = ESPERA;
        w_ptr_next    = w_ptr_inc;
        w_valido_next = 1'b1;
        w_cnt_next    = 4'(HOLD - 1);
      end
      ESPERA: begin
        if (r_cnt == 4'd0) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_cnt      <= '0;
      r_reg_in   <= '0;
      r_ack      <= '0;
      r_leer     <= 1'b0;
      r_grant_id <= '0;
      r_valido   <= 1'b0;
      r_ocupado  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_cnt      <= w_cnt_next;
      r_reg_in   <= w_reg_in_next;
      r_ack      <= w_ack_next;
      r_leer     <= w_leer_next;
      r_grant_id <= w_grant_id_next;
      r_valido   <= w_valido_next;
      r_ocupado  <= (w_state_next != IDLE);
    end
  end

  assign io_bus.ack      = r_ack;
  assign io_bus.reg_in   = r_reg_in;
  assign io_bus.leer     = r_leer;
  assign io_bus.grant_id = r_grant_id;
  assign io_bus.valido   = r_valido;
  assign io_bus.ocupado  = r_ocupado;
endmodule

// File: tb/tb_arbitro_regs.sv
// Bench for arbitro_regs: directed scenarios plus random traffic, checked every
// cycle against a grant-timing model of the arbiter and a stand-in regs register.
module tb_arbitro_regs;
  localparam int N    = 4;
  localparam int W    = 25;
  localparam int IDW  = 2;
  localparam int HOLD = 3;
  localparam int OW   = N + W + 1 + IDW + 1 + 1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  arbitro_regs_if #(.N_REQ(N), .WIDTH(W), .ID_W(IDW)) bus ();

  arbitro_regs #(.N_REQ(N), .WIDTH(W), .ID_W(IDW), .HOLD(HOLD)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream regs: plain load register without reset
  logic [W-1:0] regs_out;
  always @(posedge clk) if (bus.leer === 1'b1) regs_out <= bus.reg_in;

  // Model: a grant happens at an edge when out of reset, at least HOLD+2 edges
  // after the previous grant (or one edge after reset), and some req is high.
  int              cyc;
  int              m_g;
  int              m_free;
  int              m_ptr;
  logic [W-1:0]    m_reg_in;
  logic [IDW-1:0]  m_gid;
  logic [OW-1:0]   exp_v;

  task automatic model_edge(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] dt);
    int d;
    int w;
    if (!r) begin
      m_ptr = 0; m_free = cyc + 1; m_g = -1000;
      m_reg_in = '0; m_gid = '0; exp_v = '0;
    end else if (cyc >= m_free && rq != '0) begin
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      m_g = cyc; m_free = cyc + HOLD + 2; m_ptr = (w + 1) % N;
      m_reg_in = dt[w*W +: W];
      m_gid = IDW'(w);
      exp_v = {N'(1 << w), m_reg_in, 1'b1, m_gid, 1'b0, 1'b1};
    end else begin
      d = cyc - m_g;
      exp_v = {N'(0), m_reg_in, 1'b0, m_gid, 1'(d == 1), 1'(d >= 1 && d <= HOLD)};
    end
    cyc++;
  endtask

  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] dt);
    @(negedge clk);
    rst_n = r; bus.req = rq; bus.dato = dt;
    @(posedge clk);
    model_edge(r, rq, dt);
    #1;
  endtask

  function automatic logic [OW-1:0] obs();
    return {bus.ack, bus.reg_in, bus.leer, bus.grant_id, bus.valido, bus.ocupado};
  endfunction

  function automatic logic [N*W-1:0] rand_dato();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'($urandom);
    return d;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 4'hF, rand_dato());
      checks++;
      if (obs() !== '0) begin
        errors++; $display("FAIL reset_outputs cyc=%0d got=%h exp=0", cyc, obs());
      end
    end
    step(1'b1, 4'hF, rand_dato());
    checks++;
    if (obs() !== exp_v || bus.grant_id !== 2'd0 || bus.leer !== 1'b1) begin
      errors++; $display("FAIL reset_first_grant got=%h exp=%h", obs(), exp_v);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'h0, rand_dato());
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL reset_drain cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
      end
    end
  endtask

  task automatic test_single();
    logic [N*W-1:0] d;
    int leers;
    d = rand_dato();
    d[2*W +: W] = 25'h1AAAAAA;
    step(1'b1, 4'b0100, d);
    leers = (bus.leer === 1'b1) ? 1 : 0;
    checks++;
    if (bus.reg_in !== 25'h1AAAAAA || bus.ack !== 4'b0100 || bus.grant_id !== 2'd2 || obs() !== exp_v) begin
      errors++; $display("FAIL single_grant got=%h exp=%h", obs(), exp_v);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'h0, rand_dato());
      if (bus.leer === 1'b1) leers++;
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL single_cycle cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
      end
      if (i == 0) begin
        checks++;
        if (bus.valido !== 1'b1 || regs_out !== 25'h1AAAAAA) begin
          errors++; $display("FAIL single_valido valido=%b regs=%h exp regs=1aaaaaa", bus.valido, regs_out);
        end
      end
    end
    checks++;
    if (leers != 1) begin
      errors++; $display("FAIL single_leer_count got=%0d exp=1", leers);
    end
  endtask

  task automatic test_contention();
    logic [N*W-1:0] d;
    int ids[$];
    int at[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) d[i*W +: W] = {W'($urandom) & ~W'(3)} | W'(i);
    step(1'b0, 4'h0, d);
    for (int i = 0; i < 25; i++) begin
      step(1'b1, 4'hF, d);
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL contention_cycle cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
      end
      if (bus.leer === 1'b1) begin
        ids.push_back(int'(bus.grant_id)); at.push_back(cyc);
        checks++;
        if (bus.reg_in !== d[int'(bus.grant_id)*W +: W]) begin
          errors++; $display("FAIL contention_word got=%h exp=%h", bus.reg_in, d[int'(bus.grant_id)*W +: W]);
        end
      end
    end
    checks++;
    if (ids.size() != 5) begin
      errors++; $display("FAIL contention_count got=%0d exp=5", ids.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (ids[i] != exp_order[i]) begin
          errors++; $display("FAIL contention_order idx=%0d got=%0d exp=%0d", i, ids[i], exp_order[i]);
        end
        if (i > 0) begin
          checks++;
          if (at[i] - at[i-1] != HOLD + 2) begin
            errors++; $display("FAIL contention_spacing idx=%0d got=%0d exp=%0d", i, at[i] - at[i-1], HOLD + 2);
          end
        end
      end
    end
  endtask

  task automatic test_rotation();
    int ids[$];
    step(1'b0, 4'h0, rand_dato());
    step(1'b1, 4'b0010, rand_dato());
    checks++;
    if (bus.grant_id !== 2'd1 || obs() !== exp_v) begin
      errors++; $display("FAIL rotation_setup got=%h exp=%h", obs(), exp_v);
    end
    for (int i = 0; i < 4; i++) step(1'b1, 4'h0, rand_dato());
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 4'b1010, rand_dato());
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL rotation_cycle cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
      end
      if (bus.leer === 1'b1) ids.push_back(int'(bus.grant_id));
    end
    checks++;
    if (ids.size() < 2 || ids[0] != 3 || ids[1] != 1) begin
      errors++; $display("FAIL rotation_order got=%p exp=3,1 first", ids);
    end
    for (int i = 0; i < 6; i++) step(1'b1, 4'h0, rand_dato());
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'b0010, rand_dato());
    checks++;
    if (bus.leer !== 1'b1 || bus.grant_id !== 2'd1) begin
      errors++; $display("FAIL midreset_grant got=%h exp=%h", obs(), exp_v);
    end
    step(1'b0, 4'b0010, rand_dato());
    checks++;
    if (bus.leer !== 1'b0 || bus.ack !== 4'b0 || obs() !== '0) begin
      errors++; $display("FAIL midreset_clear got=%h exp=0", obs());
    end
    // req[3] also pending: only a cleared pointer lets requester 1 win
    step(1'b1, 4'b1010, rand_dato());
    checks++;
    if (bus.grant_id !== 2'd1 || bus.ack !== 4'b0010 || obs() !== exp_v) begin
      errors++; $display("FAIL midreset_regrant got=%h exp=%h", obs(), exp_v);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 4'h0, rand_dato());
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL midreset_drain cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
      end
    end
  endtask

  task automatic test_lost_pulse();
    logic [N-1:0] rq;
    int leers;
    step(1'b1, 4'b0100, rand_dato());
    leers = (bus.leer === 1'b1) ? 1 : 0;
    for (int i = 1; i < 10; i++) begin
      rq = (i == 2 || i == 3) ? 4'b0001 : 4'b0000;
      step(1'b1, rq, rand_dato());
      if (bus.leer === 1'b1) leers++;
      checks++;
      if (obs() !== exp_v || bus.ack[0] !== 1'b0) begin
        errors++; $display("FAIL lost_cycle cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
      end
    end
    checks++;
    if (leers != 1 || bus.ocupado !== 1'b0) begin
      errors++; $display("FAIL lost_summary leers=%0d ocupado=%b exp leers=1 ocupado=0", leers, bus.ocupado);
    end
  endtask

  task automatic test_random();
    logic r;
    logic [N-1:0] rq;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 63) != 0);
      rq = ($urandom_range(0, 3) == 0) ? 4'h0 : N'($urandom);
      step(r, rq, rand_dato());
      checks++;
      if (obs() !== exp_v) begin
        errors++; $display("FAIL random_cycle cyc=%0d got=%h exp=%h", cyc, obs(), exp_v);
      end
      if (exp_v[1] === 1'b1) begin
        checks++;
        if (regs_out !== m_reg_in) begin
          errors++; $display("FAIL random_regs cyc=%0d got=%h exp=%h", cyc, regs_out, m_reg_in);
        end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    m_g = -1000; m_free = 0; m_ptr = 0; m_reg_in = '0; m_gid = '0; exp_v = '0;
    rst_n = 1'b0; bus.req = '0; bus.dato = '0;
    test_reset();
    test_single();
    test_contention();
    test_rotation();
    test_reset_mid();
    test_lost_pulse();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
